// File: rtl/weibuf_pkg.sv
// Shared types and constants for the weight-buffer read engine.
//   WEIBUF_ADDR_W / WEIBUF_DATA_W / WEIBUF_LEN_W : default widths
//   weibuf_rd_state_e : read-engine FSM states
//   weibuf_beat_t     : one stream beat (word + last marker)
package weibuf_pkg;

  localparam int unsigned WEIBUF_ADDR_W = 10;
  localparam int unsigned WEIBUF_DATA_W = 64;
  localparam int unsigned WEIBUF_LEN_W  = 11;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } weibuf_rd_state_e;

  typedef struct packed {
    logic [WEIBUF_DATA_W-1:0] data;
    logic                     last;
  } weibuf_beat_t;

endpackage

// File: rtl/weibuf_skid_fifo.sv
// Two-entry register FIFO for stream beats. The head entry is a plain
// register so the stream outputs never pass through a read mux.
//   clk, rst : clock, synchronous active-high reset
//   push/din : write a beat (caller guarantees space)
//   pop      : remove head beat (caller guarantees non-empty)
//   head     : current head beat
//   count    : occupancy 0..2
module weibuf_skid_fifo
  import weibuf_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  weibuf_beat_t din,
  input  logic         pop,
  output weibuf_beat_t head,
  output logic [1:0]   count
);

  weibuf_beat_t tail;

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (pop) begin
      // On pop the tail (if any) shifts forward; a simultaneous push lands
      // behind whatever remains.
      if (count == 2'd2) begin
        head <= tail;
        if (push) tail <= din;
      end else if (push) begin
        head <= din;
      end
      count <= count - 2'd1 + {1'b0, push};
    end else if (push) begin
      if (count == 2'd0) head <= din;
      else               tail <= din;
      count <= count + 2'd1;
    end
  end

endmodule

// File: rtl/weibuf_reader.sv
// Streaming read engine for the 1024x64 weight buffer. Issues reads from
// base_addr for len words (wrapping), absorbs the one-cycle read latency,
// and delivers words on a valid/ready stream with full backpressure.
//   clkb, rstb            : clock, synchronous active-high reset
//   start, base_addr, len : job request (sampled in IDLE only)
//   busy, done            : job in progress / one-cycle completion pulse
//   enb, addrb, doutb     : buffer read port (data valid cycle after enb)
//   m_valid, m_data, m_last, m_ready : output stream
module weibuf_reader
  import weibuf_pkg::*;
#(
  parameter int unsigned ADDR_W = WEIBUF_ADDR_W,
  parameter int unsigned DATA_W = WEIBUF_DATA_W,
  parameter int unsigned LEN_W  = WEIBUF_LEN_W
) (
  input  logic              clkb,
  input  logic              rstb,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              enb,
  output logic [ADDR_W-1:0] addrb,
  input  logic [DATA_W-1:0] doutb,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  input  logic              m_ready
);

  weibuf_rd_state_e state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  rem_q;
  logic              inflight_q;
  logic              last_inflight_q;
  logic              pop;
  logic              final_rd;
  logic [2:0]        occ;
  logic [1:0]        fifo_count;
  weibuf_beat_t      fifo_din;
  weibuf_beat_t      fifo_head;

  assign pop = m_valid & m_ready;

  // Slots committed after this cycle's pop; a read may only be issued when
  // its returning word is guaranteed a FIFO slot.
  assign occ      = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
  assign enb      = (state_q == RUN) && (rem_q != '0) && (occ < 3'd2);
  assign final_rd = enb && (rem_q == LEN_W'(1));
  assign addrb    = addr_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = (len != '0) ? RUN : DONE;
      RUN:     if (final_rd) state_d = DRAIN;
      DRAIN:   if (pop && m_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == RUN) || (state_q == DRAIN);
  assign done = (state_q == DONE);

  always_ff @(posedge clkb) begin
    if (rstb) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      rem_q           <= '0;
      inflight_q      <= 1'b0;
      last_inflight_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      inflight_q      <= enb;
      last_inflight_q <= final_rd;
      if (state_q == IDLE && start) begin
        addr_q <= base_addr;
        rem_q  <= len;
      end else if (enb) begin
        addr_q <= addr_q + ADDR_W'(1);
        rem_q  <= rem_q - LEN_W'(1);
      end
    end
  end

  assign fifo_din = '{data: doutb, last: last_inflight_q};

  weibuf_skid_fifo u_fifo (
    .clk   (clkb),
    .rst   (rstb),
    .push  (inflight_q),
    .din   (fifo_din),
    .pop   (pop),
    .head  (fifo_head),
    .count (fifo_count)
  );

  assign m_valid = (fifo_count != 2'd0);
  assign m_data  = fifo_head.data;
  assign m_last  = fifo_head.last;

endmodule

// File: tb/tb_weibuf_reader.sv
// Self-checking bench for weibuf_reader: a behavioural RAM behind the read
// port, and per-job expected word queues built from base/len arithmetic.
module tb_weibuf_reader;

  logic        clkb;
  logic        rstb;
  logic        start;
  logic [9:0]  base_addr;
  logic [10:0] len;
  logic        busy;
  logic        done;
  logic        enb;
  logic [9:0]  addrb;
  logic [63:0] doutb = '0;
  logic        m_valid;
  logic [63:0] m_data;
  logic        m_last;
  logic        m_ready;

  logic [63:0] ram [1024];

  int checks   = 0;
  int failures = 0;

  weibuf_reader #(
    .ADDR_W (10),
    .DATA_W (64),
    .LEN_W  (11)
  ) dut (
    .clkb      (clkb),
    .rstb      (rstb),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .enb       (enb),
    .addrb     (addrb),
    .doutb     (doutb),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_last    (m_last),
    .m_ready   (m_ready)
  );

  initial begin
    clkb = 1'b0;
    forever #5 clkb = ~clkb;
  end

  // Buffer model: one-cycle read latency.
  always @(posedge clkb) if (enb === 1'b1) doutb <= ram[addrb];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clkb); #1;
      chk("idle_enb", enb, 0);
      chk("idle_valid", m_valid, 0);
      chk("idle_done", done, 0);
    end
  endtask

  // mode 0: m_ready held high, exact cycle timing checked.
  // mode 1: random m_ready with a forced 10-cycle stall.
  task automatic run_job(input logic [9:0] b, input logic [10:0] n, input int mode,
                         input int restart_cyc, input int abort_beat, output bit aborted);
    int          cyc     = 0;
    int          issued  = 0;
    int          popped  = 0;
    int          budget  = 4 * int'(n) + 60;
    bit          fin     = 0;
    bit          prev_stall = 0;
    logic [63:0] prev_data = '0;
    logic        prev_last = 1'b0;
    logic [63:0] q_data[$];
    bit          q_last[$];
    for (int i = 0; i < int'(n); i++) begin
      q_data.push_back(ram[(int'(b) + i) % 1024]);
      q_last.push_back(i == int'(n) - 1);
    end
    aborted   = 0;
    base_addr = b;
    len       = n;
    start     = 1'b1;
    while (!fin && cyc < budget) begin
      @(negedge clkb);
      cyc++;
      start = (cyc == restart_cyc);
      if (cyc == restart_cyc) begin
        base_addr = 10'h000;
        len       = 11'd5;
      end
      if (mode == 0) m_ready = 1'b1;
      else if (cyc >= 8 && cyc < 18) m_ready = 1'b0;
      else m_ready = 1'($urandom_range(0, 1));
      #1;
      if (prev_stall) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_data", m_data, prev_data);
        chk("hold_last", m_last, prev_last);
      end
      if (enb) begin
        chk("addrb", addrb, 64'((int'(b) + issued) % 1024));
        issued++;
      end
      if (m_valid && m_ready) begin
        if (q_data.size() == 0) chk("extra_beat", popped, n);
        else begin
          chk("beat_data", m_data, q_data.pop_front());
          chk("beat_last", m_last, q_last.pop_front());
        end
        popped++;
      end
      chk("outstanding_le2", (issued - popped) <= 2, 1);
      if (mode == 0) begin
        chk("enb_timing", enb, cyc <= int'(n));
        chk("valid_timing", m_valid, cyc >= 3 && cyc <= int'(n) + 2);
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      if (done) begin
        chk("busy_at_done", busy, 0);
        chk("beats_at_done", popped, n);
        if (mode == 0) chk("done_cycle", cyc, (n == 0) ? 1 : int'(n) + 3);
        fin = 1;
      end else begin
        chk("busy", busy, n != 0);
      end
      if (abort_beat > 0 && popped >= abort_beat) begin
        aborted = 1;
        fin     = 1;
      end
    end
    if (!fin) chk("timeout_done", done, 1);
    start = 1'b0;
  endtask

  initial begin
    bit ab;
    for (int i = 0; i < 1024; i++) ram[i] = {$urandom(), $urandom()};
    rstb      = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    len       = '0;
    m_ready   = 1'b1;
    repeat (3) @(negedge clkb);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_enb", enb, 0);
    chk("rst_addrb", addrb, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_last", m_last, 0);
    rstb = 1'b0;
    idle_check(2);

    run_job(10'h010, 11'd4, 0, 0, 0, ab);
    idle_check(3);
    run_job(10'h3FE, 11'd4, 0, 0, 0, ab);
    idle_check(3);
    run_job(10'($urandom_range(0, 1023)), 11'd16, 1, 12, 0, ab);
    idle_check(3);
    run_job(10'h123, 11'd0, 0, 0, 0, ab);
    idle_check(3);
    run_job(10'h200, 11'd1024, 0, 0, 0, ab);
    idle_check(3);

    run_job(10'($urandom_range(0, 1023)), 11'd16, 0, 0, 5, ab);
    chk("abort_reached", ab, 1);
    rstb = 1'b1;
    @(negedge clkb); #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_enb", enb, 0);
    chk("midrst_addrb", addrb, 0);
    chk("midrst_valid", m_valid, 0);
    chk("midrst_data", m_data, 0);
    chk("midrst_last", m_last, 0);
    rstb = 1'b0;
    idle_check(4);

    run_job(10'($urandom_range(0, 1023)), 11'd8, 1, 0, 0, ab);
    idle_check(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/weibuf_reader.md
# weibuf_reader

Streaming read engine for the 1024×64 CNN weight buffer: given a start address and word count, it issues read requests on the buffer's read port, absorbs the one-cycle read latency, and delivers words to the PE-array weight loader over a valid/ready stream with full backpressure. It sits directly downstream of `buf_wrapper` on the `clkb` domain and is the only driver of that wrapper's `enb`/`addrb`.

## Interface
Parameters:
- `ADDR_W`, 10, buffer address width.
- `DATA_W`, 64, buffer word width.
- `LEN_W`, 11, word-count width; allows 0..1024.

Ports:
- `clkb`  in  1  clock, the buffer read-side clock.
- `rstb`  in  1  reset, synchronous, active-high.
- `start`  in  1  one-cycle job request; sampled only in IDLE.
- `base_addr`  in  ADDR_W  first word address; sampled with `start`.
- `len`  in  LEN_W  number of words; sampled with `start`.
- `busy`  out  1  job in progress.
- `done`  out  1  one-cycle completion pulse.
- `enb`  out  1  buffer read enable.
- `addrb`  out  ADDR_W  buffer read address.
- `doutb`  in  DATA_W  buffer read data, valid the cycle after `enb`.
- `m_valid`  out  1  stream data valid.
- `m_data`  out  DATA_W  stream word.
- `m_last`  out  1  marks the final word of the job.
- `m_ready`  in  1  consumer ready.

Decided: one clock (`clkb`); reset (`rstb`) is synchronous and active-high.

## Operation
- FSM states:
  - IDLE: `start`=1 and `len`≠0 → RUN. `start`=1 and `len`=0 → DONE. `start` in any other state is ignored.
  - RUN: issues reads. Moves to DRAIN in the cycle after the read for the final address is issued.
  - DRAIN: waits for the last beat to handshake (`m_valid & m_ready & m_last`), then → DONE.
  - DONE: `done`=1 for one cycle, then → IDLE.
- Address counter:
  - Loaded with `base_addr`; increments by 1 per issued read.
  - Wraps modulo 2^ADDR_W; 1023 → 0 is legal.
- Remaining-read counter:
  - Loaded with `len`; decrements per issued read.
  - The final read is the one issued when the counter equals 1.
- Output FIFO (2 entries):
  - Captures `doutb` the cycle after each `enb`.
  - A beat transfers when `m_valid & m_ready`.
  - `m_data`/`m_last` hold stable while `m_valid & !m_ready`.
- Credit rule: `enb`=1 only in RUN with remaining>0 and (fifo_count + inflight − pop) < 2, where pop = `m_valid & m_ready`. No read is ever issued whose data could not be stored.
- `m_last`: tagged onto the word returned by the final read; travels with that FIFO entry.
- Reset mid-job: FSM, counters, FIFO and inflight flag all clear. Data returning on `doutb` the following cycle is discarded.

## Timing
- Reset values: `busy`=0, `done`=0, `enb`=0, `addrb`=0, `m_valid`=0, `m_data`=0, `m_last`=0.
- `start` accepted at cycle 0:
  - `busy`=1 from cycle 1.
  - `enb`=1 with `addrb`=`base_addr` in cycle 1.
  - Data captured at end of cycle 2; `m_valid`=1 in cycle 3.
- With `m_ready` held high: one beat per cycle sustained; N words complete at cycle N+2.
- `done`: asserted the cycle after the last-beat handshake. `busy` deasserts in that same cycle.
- `len`=0: `done`=1 in cycle 1; `enb` and `m_valid` stay 0.
- `enb`/`addrb` are driven combinationally from registered state and the credit rule. All stream outputs come from registers.

## Structure
- Package `weibuf_pkg` holds:
  - constants `WEIBUF_ADDR_W`=10, `WEIBUF_DATA_W`=64, `WEIBUF_LEN_W`=11;
  - enum `weibuf_rd_state_e` {IDLE, RUN, DRAIN, DONE};
  - struct `weibuf_beat_t` {data, last}.
- Sub-module `weibuf_skid_fifo`: 2-entry register FIFO of `weibuf_beat_t` with push/pop/count. The top-level implements the FSM, counters and credit logic.

## Test plan
- `base_addr`=0x010, `len`=4, `m_ready`=1:
  - `addrb` 0x010..0x013 in cycles 1–4;
  - beats equal to RAM contents in cycles 3–6;
  - `m_last` on the 4th beat; `done` in cycle 7.
- `base_addr`=0x3FE, `len`=4: reads 0x3FE, 0x3FF, 0x000, 0x001, in order; data matches.
- `len`=16, `m_ready` toggling randomly plus a 10-cycle stall:
  - all 16 words delivered once, in order;
  - `m_data` stable during stalls;
  - never more than 2 outstanding (FIFO + inflight).
- `len`=0: `done` pulse in cycle 1; no `enb`, no `m_valid`. A second `start` while `busy` is ignored, and the job's beat count is unchanged.
- `len`=1024 from 0x200: exactly 1024 beats, `m_last` only on the last.
- `rstb` pulsed mid-job at beat 5: all outputs 0 the next cycle; no stale beat afterwards. A new job runs correctly.
